// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered common data bus among NUM_REQ functional units.
// Each unit hands off a result into a private one-entry slot; one full slot is broadcast per cycle.
module cdb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  localparam int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [SRC_W-1:0]              cdb_src
);

  // Handshake: a result transfers from FU i at a posedge where req_valid[i] && req_ready[i];
  // the FU holds valid/tag/data stable until then. The CDB side has no back-pressure.

  logic [NUM_REQ-1:0]    full;
  logic [TAG_WIDTH-1:0]  slot_tag  [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];
  logic [SRC_W-1:0]      rr_ptr;

  logic [NUM_REQ-1:0]    grant;
  logic                  grant_any;
  logic [SRC_W-1:0]      winner;
  logic [NUM_REQ-1:0]    accept;

  // Scan from rr_ptr upward with wrap; the first full slot wins.
  always_comb begin
    int sum;
    logic [SRC_W-1:0] idx;
    grant_any = 1'b0;
    winner    = '0;
    grant     = '0;
    sum       = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = SRC_W'(sum);
      if (!grant_any && full[idx]) begin
        grant_any = 1'b1;
        winner    = idx;
      end
    end
    if (grant_any) grant[winner] = 1'b1;
  end

  // A slot being broadcast this cycle can be refilled at the same edge.
  assign req_ready = {NUM_REQ{!flush}} & (~full | grant);
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full      <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      // Pending results are discarded; a broadcast already on the bus is left to consumers.
      full      <= '0;
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) full[i] <= 1'b1;
        else if (grant[i]) full[i] <= 1'b0;
      end
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_tag  <= slot_tag[winner];
        cdb_data <= slot_data[winner];
        cdb_src  <= winner;
        rr_ptr   <= (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  // Payload registers need no reset; they are only read while the matching full bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        slot_tag[i]  <= req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        slot_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts (with their cycle) go into a queue,
// and a negedge monitor pops and compares every cdb_valid cycle.
module tb_cdb_arbiter;
  localparam int N  = 3;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int EW = 16 + SW + TW + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_bc(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                           input logic [SW-1:0] src, input int at);
    exp_q.push_back({16'(at), src, tag, data});
  endtask

  // driver tasks
  task automatic drive(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    req_valid[i]          = 1'b1;
    req_tag[i*TW +: TW]   = tag;
    req_data[i*DW +: DW]  = data;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: every broadcast must match the head of the expected queue, including its cycle
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    if (rst_n && cdb_valid) begin
      got = {16'(cyc), cdb_src, cdb_tag, cdb_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got tag %0d data %h src %0d at cycle %0d, required no broadcast",
                 cdb_tag, cdb_data, cdb_src, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL cdb_broadcast: got cyc %0d src %0d tag %0d data %h, required cyc %0d src %0d tag %0d data %h",
                   got[EW-1 -: 16], got[DW+TW +: SW], got[DW +: TW], got[DW-1:0],
                   want[EW-1 -: 16], want[DW+TW +: SW], want[DW +: TW], want[DW-1:0]);
        end
      end
    end
  end

  initial begin
    int c;
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = '1;
    req_tag   = '0;
    req_data  = '0;

    // reset held two cycles with all requests valid
    tick(1);
    check("reset_valid_c1", cdb_valid, 0);
    tick(1);
    check("reset_valid_c2", cdb_valid, 0);
    check("reset_tag", cdb_tag, 0);
    check("reset_data", cdb_data, 0);
    check("reset_src", cdb_src, 0);
    rst_n     = 1'b1;
    req_valid = '0;
    #1 check("reset_ready", req_ready, 3'b111);
    tick(2);

    // single FU0 result, 2-cycle latency, one-cycle pulse
    c = cyc;
    drive(0, 6'd5, 32'hDEADBEEF);
    expect_bc(6'd5, 32'hDEADBEEF, 2'd0, c + 2);
    tick(1);
    req_valid = '0;
    tick(1);
    check("single_valid", cdb_valid, 1);
    tick(1);
    check("single_idle", cdb_valid, 0);
    tick(2);

    // reset again so rr_ptr=0, then all three FUs at once
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    c = cyc;
    drive(0, 6'd1, 32'h0000_0100);
    drive(1, 6'd2, 32'h0000_0200);
    drive(2, 6'd3, 32'h0000_0300);
    expect_bc(6'd1, 32'h0000_0100, 2'd0, c + 2);
    expect_bc(6'd2, 32'h0000_0200, 2'd1, c + 3);
    expect_bc(6'd3, 32'h0000_0300, 2'd2, c + 4);
    #1 check("all3_ready_c0", req_ready, 3'b111);
    tick(1);
    req_valid = '0;
    #1 check("all3_ready_c1", req_ready, 3'b001);
    tick(1);
    #1 check("all3_ready_c2", req_ready, 3'b011);
    tick(1);
    #1 check("all3_ready_c3", req_ready, 3'b111);
    tick(3);

    // FU1 alone moves rr_ptr to 2; then FU0 and FU2 together: FU2 wins first
    c = cyc;
    drive(1, 6'd4, 32'h0000_0044);
    expect_bc(6'd4, 32'h0000_0044, 2'd1, c + 2);
    tick(1);
    req_valid = '0;
    tick(2);
    drive(0, 6'd7, 32'h0000_0077);
    drive(2, 6'd9, 32'h0000_0099);
    expect_bc(6'd9, 32'h0000_0099, 2'd2, c + 5);
    expect_bc(6'd7, 32'h0000_0077, 2'd0, c + 6);
    tick(1);
    req_valid = '0;
    tick(4);

    // FU0 streams four results back to back
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      drive(0, 6'(10 + k), 32'h0000_1000 + 32'(k));
      expect_bc(6'(10 + k), 32'h0000_1000 + 32'(k), 2'd0, c + 2 + k);
      #1 check("stream_ready0", req_ready[0], 1);
      tick(1);
    end
    req_valid = '0;
    tick(4);

    // slots 0 and 2 filled, flush with FU1 valid: nothing is broadcast or accepted
    drive(0, 6'd20, 32'h0000_2020);
    drive(2, 6'd22, 32'h0000_2222);
    tick(1);
    req_valid = '0;
    drive(1, 6'd21, 32'h0000_2121);
    flush = 1'b1;
    #1 check("flush_ready", req_ready, 3'b000);
    tick(1);
    flush     = 1'b0;
    req_valid = '0;
    check("flush_valid", cdb_valid, 0);
    #1 check("flush_ready_after", req_ready, 3'b111);
    tick(4);

    // reset while a slot is full: the pending result is lost
    drive(1, 6'd30, 32'h0000_3030);
    tick(1);
    req_valid = '0;
    rst_n     = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midreset_valid", cdb_valid, 0);
    #1 check("midreset_ready", req_ready, 3'b111);
    tick(3);

    // rr_ptr restarted at 0: FU0 beats FU1
    c = cyc;
    drive(0, 6'd40, 32'h0000_4040);
    drive(1, 6'd41, 32'h0000_4141);
    expect_bc(6'd40, 32'h0000_4040, 2'd0, c + 2);
    expect_bc(6'd41, 32'h0000_4141, 2'd1, c + 3);
    tick(1);
    req_valid = '0;
    tick(5);

    // report
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
